// File: rtl/noc_packetizer.sv
// Network-interface transmit stage: turns a (dst, len) command plus payload words
// into a header/body/tail flit stream on a registered valid/ready channel.
module noc_packetizer #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned COORD_W = 4,
    parameter int unsigned LEN_W   = 8,
    parameter int unsigned SRC_X   = 0,
    parameter int unsigned SRC_Y   = 0
) (
    input  logic               noc_clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [COORD_W-1:0] cmd_dst_x,
    input  logic [COORD_W-1:0] cmd_dst_y,
    input  logic [LEN_W-1:0]   cmd_len,
    input  logic               pl_valid,
    output logic               pl_ready,
    input  logic [DATA_W-1:0]  pl_data,
    output logic               flit_valid,
    input  logic               flit_ready,
    output logic [DATA_W-1:0]  flit_data,
    output logic               flit_is_header,
    output logic               flit_is_tail,
    input  logic               vc_ready,
    output logic               busy
);

    localparam int unsigned HDR_W = LEN_W + 4 * COORD_W;

    typedef enum logic {
        S_IDLE,
        S_BODY
    } state_t;

    state_t             r_state;
    logic [LEN_W-1:0]   r_rem;
    logic               r_flit_valid;
    logic               r_is_header;
    logic               r_is_tail;
    logic [DATA_W-1:0]  r_flit_data;

    logic               w_slot_free;
    logic               w_cmd_fire;
    logic               w_pl_fire;
    logic [HDR_W-1:0]   w_hdr_bits;
    logic [DATA_W-1:0]  w_header;

    // Output register can take a new flit when empty or draining this cycle
    assign w_slot_free = !r_flit_valid || flit_ready;
    assign cmd_ready   = !rst && (r_state == S_IDLE) && w_slot_free && vc_ready;
    assign pl_ready    = (r_state == S_BODY) && w_slot_free;
    assign w_cmd_fire  = cmd_valid && cmd_ready;
    assign w_pl_fire   = pl_valid && pl_ready;

    assign w_hdr_bits = {COORD_W'(SRC_X), COORD_W'(SRC_Y), cmd_dst_x, cmd_dst_y, cmd_len};
    assign w_header   = DATA_W'(w_hdr_bits);

    assign flit_valid     = r_flit_valid;
    assign flit_data      = r_flit_data;
    assign flit_is_header = r_is_header;
    assign flit_is_tail   = r_is_tail;
    assign busy           = (r_state == S_BODY) || r_flit_valid;

    // Packet FSM and output flit register
    always_ff @(posedge noc_clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_rem        <= '0;
            r_flit_valid <= 1'b0;
            r_is_header  <= 1'b0;
            r_is_tail    <= 1'b0;
            r_flit_data  <= '0;
        end else begin
            if (w_slot_free) begin
                r_flit_valid <= 1'b0;
                r_is_header  <= 1'b0;
                r_is_tail    <= 1'b0;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_cmd_fire) begin
                        r_flit_valid <= 1'b1;
                        r_flit_data  <= w_header;
                        r_is_header  <= 1'b1;
                        r_is_tail    <= (cmd_len == '0);
                        r_rem        <= cmd_len;
                        r_state      <= (cmd_len == '0) ? S_IDLE : S_BODY;
                    end
                end
                S_BODY: begin
                    if (w_pl_fire) begin
                        r_flit_valid <= 1'b1;
                        r_flit_data  <= pl_data;
                        r_is_header  <= 1'b0;
                        r_is_tail    <= (r_rem == LEN_W'(1));
                        r_rem        <= r_rem - LEN_W'(1);
                        if (r_rem == LEN_W'(1)) begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_noc_packetizer.sv
// Self-checking bench for noc_packetizer: directed vector table, reset corner
// sequence, and randomized traffic scored against a flit-queue reference model.
module tb_noc_packetizer;

    logic        noc_clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_dst_x;
    logic [3:0]  cmd_dst_y;
    logic [7:0]  cmd_len;
    logic        pl_valid;
    logic        pl_ready;
    logic [31:0] pl_data;
    logic        flit_valid;
    logic        flit_ready;
    logic [31:0] flit_data;
    logic        flit_is_header;
    logic        flit_is_tail;
    logic        vc_ready;
    logic        busy;

    int n_checks = 0;
    int n_err    = 0;

    noc_packetizer #(
        .DATA_W(32), .COORD_W(4), .LEN_W(8), .SRC_X(0), .SRC_Y(0)
    ) dut (
        .noc_clk(noc_clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_dst_x(cmd_dst_x), .cmd_dst_y(cmd_dst_y), .cmd_len(cmd_len),
        .pl_valid(pl_valid), .pl_ready(pl_ready), .pl_data(pl_data),
        .flit_valid(flit_valid), .flit_ready(flit_ready), .flit_data(flit_data),
        .flit_is_header(flit_is_header), .flit_is_tail(flit_is_tail),
        .vc_ready(vc_ready), .busy(busy)
    );

    initial noc_clk = 1'b0;
    always #5 noc_clk = ~noc_clk;

    typedef struct {
        logic        cv;
        logic [3:0]  dx;
        logic [3:0]  dy;
        logic [7:0]  len;
        logic        pv;
        logic [31:0] pd;
        logic        fr;
        logic        vc;
        logic        e_fv;
        logic [31:0] e_fd;
        logic        e_hd;
        logic        e_tl;
        logic        e_cr;
        logic        e_pr;
        logic        e_busy;
    } vec_t;

    typedef struct {
        logic [31:0] d;
        logic        h;
        logic        t;
    } flit_t;

    vec_t  tv[28];
    flit_t exp_q[$];

    function automatic vec_t mkv(input logic cv, input logic [3:0] dx, input logic [3:0] dy,
                                 input logic [7:0] len, input logic pv, input logic [31:0] pd,
                                 input logic fr, input logic vc, input logic efv,
                                 input logic [31:0] efd, input logic ehd, input logic etl,
                                 input logic ecr, input logic epr, input logic eb);
        vec_t v;
        v.cv = cv; v.dx = dx; v.dy = dy; v.len = len; v.pv = pv; v.pd = pd;
        v.fr = fr; v.vc = vc; v.e_fv = efv; v.e_fd = efd; v.e_hd = ehd; v.e_tl = etl;
        v.e_cr = ecr; v.e_pr = epr; v.e_busy = eb;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic cv, input logic [3:0] dx, input logic [3:0] dy,
                         input logic [7:0] len, input logic pv, input logic [31:0] pd,
                         input logic fr, input logic vc);
        cmd_valid = cv; cmd_dst_x = dx; cmd_dst_y = dy; cmd_len = len;
        pl_valid = pv; pl_data = pd; flit_ready = fr; vc_ready = vc;
    endtask

    task automatic chk_outs(input string tag, input logic efv, input logic [31:0] efd,
                            input logic ehd, input logic etl, input logic ecr,
                            input logic epr, input logic eb);
        chk({tag, ".flit_valid"}, 32'(flit_valid), 32'(efv));
        chk({tag, ".cmd_ready"},  32'(cmd_ready),  32'(ecr));
        chk({tag, ".pl_ready"},   32'(pl_ready),   32'(epr));
        chk({tag, ".busy"},       32'(busy),       32'(eb));
        if (efv) begin
            chk({tag, ".flit_data"}, flit_data, efd);
            chk({tag, ".is_header"}, 32'(flit_is_header), 32'(ehd));
            chk({tag, ".is_tail"},   32'(flit_is_tail),   32'(etl));
        end
    endtask

    // Reference header: coordinates and length packed by plain arithmetic
    function automatic logic [31:0] hdr_of(input int dx, input int dy, input int len);
        return 32'(dx * 4096 + dy * 256 + len);
    endfunction

    int    m_rem;
    logic  m_slot, m_cr, m_pr;
    flit_t f;
    logic  long_sent, long_done, in_long;
    int    long_cnt;

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        #2 rst = 1'b1;
        @(negedge noc_clk);
        chk("reset.flit_valid", 32'(flit_valid), 0);
        chk("reset.flit_data",  flit_data, 0);
        chk("reset.is_header",  32'(flit_is_header), 0);
        chk("reset.is_tail",    32'(flit_is_tail), 0);
        chk("reset.cmd_ready",  32'(cmd_ready), 0);
        chk("reset.pl_ready",   32'(pl_ready), 0);
        chk("reset.busy",       32'(busy), 0);
        @(posedge noc_clk); #1 rst = 1'b0;

        // Rows: inputs for this cycle | outputs expected at this cycle's negedge
        tv[0]  = mkv(1,2,3,3, 0,32'h0,  1,1, 0,32'h0,    0,0, 1,0,0);
        tv[1]  = mkv(0,0,0,0, 1,32'hA1, 1,1, 1,32'h2303, 1,0, 0,1,1);
        tv[2]  = mkv(0,0,0,0, 1,32'hA2, 1,1, 1,32'hA1,   0,0, 0,1,1);
        tv[3]  = mkv(0,0,0,0, 1,32'hA3, 1,1, 1,32'hA2,   0,0, 0,1,1);
        tv[4]  = mkv(0,0,0,0, 0,32'h0,  1,1, 1,32'hA3,   0,1, 1,0,1);
        tv[5]  = mkv(0,0,0,0, 0,32'h0,  1,1, 0,32'h0,    0,0, 1,0,0);
        tv[6]  = mkv(1,1,1,0, 0,32'h0,  1,1, 0,32'h0,    0,0, 1,0,0);
        tv[7]  = mkv(1,1,1,0, 0,32'h0,  1,1, 1,32'h1100, 1,1, 1,0,1);
        tv[8]  = mkv(1,1,1,0, 0,32'h0,  1,1, 1,32'h1100, 1,1, 1,0,1);
        tv[9]  = mkv(0,0,0,0, 0,32'h0,  1,1, 1,32'h1100, 1,1, 1,0,1);
        tv[10] = mkv(0,0,0,0, 0,32'h0,  1,1, 0,32'h0,    0,0, 1,0,0);
        for (int i = 11; i < 16; i++)
            tv[i] = mkv(1,5,6,0, 0,32'h0, 1,0, 0,32'h0, 0,0, 0,0,0);
        tv[16] = mkv(1,5,6,0, 0,32'h0,  1,1, 0,32'h0,    0,0, 1,0,0);
        tv[17] = mkv(0,0,0,0, 0,32'h0,  1,1, 1,32'h5600, 1,1, 1,0,1);
        tv[18] = mkv(0,0,0,0, 0,32'h0,  1,1, 0,32'h0,    0,0, 1,0,0);
        tv[19] = mkv(1,3,4,2, 0,32'h0,  1,1, 0,32'h0,    0,0, 1,0,0);
        for (int i = 20; i < 24; i++)
            tv[i] = mkv(0,0,0,0, 1,32'hB1, 0,1, 1,32'h3402, 1,0, 0,0,1);
        tv[24] = mkv(0,0,0,0, 1,32'hB1, 1,1, 1,32'h3402, 1,0, 0,1,1);
        tv[25] = mkv(0,0,0,0, 1,32'hB2, 1,1, 1,32'hB1,   0,0, 0,1,1);
        tv[26] = mkv(0,0,0,0, 1,32'hDEAD, 1,1, 1,32'hB2, 0,1, 1,0,1);
        tv[27] = mkv(0,0,0,0, 1,32'hDEAD, 1,1, 0,32'h0,  0,0, 1,0,0);

        for (int i = 0; i < 28; i++) begin
            @(posedge noc_clk); #1;
            drive(tv[i].cv, tv[i].dx, tv[i].dy, tv[i].len, tv[i].pv, tv[i].pd, tv[i].fr, tv[i].vc);
            @(negedge noc_clk);
            chk_outs($sformatf("vec%0d", i), tv[i].e_fv, tv[i].e_fd, tv[i].e_hd, tv[i].e_tl,
                     tv[i].e_cr, tv[i].e_pr, tv[i].e_busy);
        end

        // Reset in the middle of a body, then a fresh len=1 packet
        @(posedge noc_clk); #1 drive(1, 7, 7, 3, 0, 0, 1, 1);
        @(posedge noc_clk); #1 drive(0, 0, 0, 0, 1, 32'hC1, 1, 1);
        @(posedge noc_clk); #1 drive(0, 0, 0, 0, 0, 0, 1, 1);
        #2 rst = 1'b1;
        #1;
        chk_outs("midrst", 0, 0, 0, 0, 0, 0, 0);
        chk("midrst.flit_data", flit_data, 0);
        chk("midrst.is_header", 32'(flit_is_header), 0);
        chk("midrst.is_tail",   32'(flit_is_tail), 0);
        @(negedge noc_clk); rst = 1'b0;
        @(posedge noc_clk); #1 drive(1, 2, 2, 1, 0, 0, 1, 1);
        @(negedge noc_clk); chk_outs("post0", 0, 0, 0, 0, 1, 0, 0);
        @(posedge noc_clk); #1 drive(0, 0, 0, 0, 1, 32'hD1, 1, 1);
        @(negedge noc_clk); chk_outs("post1", 1, 32'h2201, 1, 0, 0, 1, 1);
        @(posedge noc_clk); #1 drive(0, 0, 0, 0, 0, 0, 1, 1);
        @(negedge noc_clk); chk_outs("post2", 1, 32'hD1, 0, 1, 1, 0, 1);
        @(posedge noc_clk); #1;
        @(negedge noc_clk); chk_outs("post3", 0, 0, 0, 0, 1, 0, 0);

        // Randomized traffic; first command is the maximum-length packet
        m_rem = 0; long_sent = 0; long_done = 0; in_long = 0; long_cnt = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge noc_clk); #1;
            drive(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  long_sent ? 8'($urandom_range(0, 5)) : 8'd255,
                  ($urandom_range(0, 9) < 7), $urandom,
                  ($urandom_range(0, 9) < 7), ($urandom_range(0, 4) != 0));
            @(negedge noc_clk);
            m_slot = (exp_q.size() == 0) || flit_ready;
            m_cr   = (m_rem == 0) && m_slot && vc_ready;
            m_pr   = (m_rem != 0) && m_slot;
            chk("rnd.flit_valid", 32'(flit_valid), 32'(exp_q.size() != 0));
            chk("rnd.cmd_ready", 32'(cmd_ready), 32'(m_cr));
            chk("rnd.pl_ready", 32'(pl_ready), 32'(m_pr));
            chk("rnd.busy", 32'(busy), 32'((m_rem != 0) || (exp_q.size() != 0)));
            if (exp_q.size() != 0) begin
                chk("rnd.flit_data", flit_data, exp_q[0].d);
                chk("rnd.is_header", 32'(flit_is_header), 32'(exp_q[0].h));
                chk("rnd.is_tail", 32'(flit_is_tail), 32'(exp_q[0].t));
                if (flit_ready) begin
                    if (exp_q[0].h && exp_q[0].d[7:0] == 8'd255) begin
                        in_long = 1; long_cnt = 1;
                    end else if (in_long) begin
                        long_cnt++;
                    end
                    if (exp_q[0].t && in_long) begin
                        chk("rnd.long_flits", 32'(long_cnt), 256);
                        in_long = 0; long_done = 1;
                    end
                    void'(exp_q.pop_front());
                end
            end
            if (cmd_valid && m_cr) begin
                f.d = hdr_of(int'(cmd_dst_x), int'(cmd_dst_y), int'(cmd_len));
                f.h = 1'b1; f.t = (cmd_len == 8'd0);
                exp_q.push_back(f);
                m_rem = int'(cmd_len);
                long_sent = 1;
            end else if (pl_valid && m_pr) begin
                f.d = pl_data; f.h = 1'b0; f.t = (m_rem == 1);
                exp_q.push_back(f);
                m_rem--;
            end
        end
        chk("rnd.long_done", 32'(long_done), 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/noc_packetizer.md
Name: noc_packetizer

Overview:
- Network-interface transmit stage that sits directly upstream of a router local-port receive channel.
- Accepts a packet command (destination, length) plus a payload word stream from a compute endpoint.
- Emits a flit stream with is_header/is_tail framing on a registered valid/ready channel.
- Starts a new packet only when the downstream virtual channel reports VCready.

Parameters:
- DATA_W, 32, flit and payload width; must be >= 24.
- COORD_W, 4, width of each X/Y coordinate field.
- LEN_W, 8, width of the payload-length field; maximum payload is 2^LEN_W-1 flits.
- SRC_X, 0, X coordinate of this node, inserted into every header.
- SRC_Y, 0, Y coordinate of this node, inserted into every header.

Ports:
- noc_clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  packet command valid
- cmd_ready  out  1  command accepted this cycle
- cmd_dst_x  in  COORD_W  destination X
- cmd_dst_y  in  COORD_W  destination Y
- cmd_len  in  LEN_W  number of payload flits; 0 means header-only packet
- pl_valid  in  1  payload word valid
- pl_ready  out  1  payload word accepted
- pl_data  in  DATA_W  payload word
- flit_valid  out  1  flit valid toward router
- flit_ready  in  1  router accepts flit
- flit_data  out  DATA_W  flit
- flit_is_header  out  1  current flit is the header
- flit_is_tail  out  1  current flit is the tail
- vc_ready  in  1  downstream VC is free for a new packet
- busy  out  1  packet in progress

Behaviour:
- Reset, asynchronous: state=IDLE; flit_valid, flit_is_header, flit_is_tail, cmd_ready, pl_ready and busy are 0; flit_data=0; remaining counter=0. Reset mid-packet abandons the packet with no tail emitted.
- Transfer rule: a flit moves only on a cycle where flit_valid and flit_ready are both 1. While flit_valid=1 and flit_ready=0, flit_data and both flags hold stable.
- The output slot is free when flit_valid=0 or flit_ready=1.
- Header format, LSB first:
  - [LEN_W-1:0] = len
  - next COORD_W bits = dst_y
  - next COORD_W bits = dst_x
  - next COORD_W bits = SRC_Y
  - next COORD_W bits = SRC_X
  - remaining upper bits = 0
- State IDLE:
  - cmd_ready = slot free AND vc_ready; this is a combinational term.
  - On cmd_valid AND cmd_ready: load the header into the output register with flit_valid=1 and is_header=1. Set remaining=cmd_len.
  - If cmd_len==0, also set is_tail=1 and stay in IDLE. This gives back-to-back header-only packets at one per cycle while vc_ready stays 1.
  - Otherwise go to BODY.
- State BODY:
  - pl_ready = slot free; this is combinational.
  - On pl_valid AND pl_ready: load pl_data with flit_valid=1, is_header=0, is_tail=(remaining==1), and decrement remaining.
  - When remaining goes 1->0, go to IDLE.
  - vc_ready is ignored in BODY; it gates only header launch.
- If the output slot frees and no new flit is loaded that cycle, flit_valid drops to 0.
- Latency: command or payload acceptance to flit_valid is 1 cycle. Sustained throughput is 1 flit/cycle.
- busy = (state==BODY) OR flit_valid.
- Boundary conditions:
  - cmd_valid during BODY is not accepted (cmd_ready=0).
  - pl_valid during IDLE is not accepted (pl_ready=0).
  - cmd_len = 2^LEN_W-1 must count correctly with no wrap.
  - Payload gaps (pl_valid=0) insert bubbles; the tail is still emitted exactly once.

Test Plan:
- cmd dst=(2,3), len=3, payloads 0xA1,0xA2,0xA3, flit_ready=1 -> 4 flits on consecutive cycles: header 0x00002303 with is_header=1, then 0xA1, 0xA2, and 0xA3 with is_tail=1; busy returns to 0 the cycle after the tail.
- cmd len=0, dst=(1,1), held for 3 cycles with vc_ready=1 -> three header+tail flits 0x00001100 on consecutive cycles; is_header=is_tail=1 each time.
- vc_ready=0 with cmd_valid=1 for 5 cycles -> cmd_ready=0 and no flit; vc_ready=1 -> header appears 1 cycle later.
- len=2 with flit_ready held 0 for 4 cycles after the header -> header held stable; pl_ready=0 throughout; after release, body flits follow with no loss or duplication.
- Reset asserted mid-BODY, after 1 of 3 payloads -> all outputs 0 immediately; a fresh len=1 packet after reset produces a correct header and a tail.
- len=255 with a random pl_valid and flit_ready pattern -> exactly 256 flits out; a single tail on the 256th; remaining never wraps.
